// File: rtl/tape_arbiter.sv
// Shares the single tape head between the UTM core and a host load/dump port.
// Host accesses seek to the target cell and back, so the core sees an unchanged tape.
module tape_arbiter #(
   parameter int ADDR_W = 9,
   parameter int SYM_W  = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              core_step,
   input  logic [SYM_W-1:0]  core_new_sym,
   input  logic              core_dir,
   output logic [SYM_W-1:0]  core_sym,
   output logic              core_sym_valid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [SYM_W-1:0]  host_wdata,
   output logic              host_ack,
   output logic [SYM_W-1:0]  host_rdata,
   output logic              host_busy,
   output logic              tape_step,
   output logic              tape_dir,
   output logic [SYM_W-1:0]  tape_new_sym,
   input  logic [SYM_W-1:0]  tape_sym,
   input  logic              tape_sym_valid,
   output logic [ADDR_W-1:0] head_pos
);

   typedef enum logic [2:0] {IDLE, CORE_WAIT, SEEK, WR, FIX, RETURN, ACK} state_t;

   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] HALF    = ADDR_W'(1) << (ADDR_W - 1);
   localparam logic              LG_HOST = 1'b1;
   localparam logic              LG_CORE = 1'b0;

   state_t            state;
   logic              outstanding;
   logic              core_pending;
   logic              core_dir_q;
   logic [SYM_W-1:0]  core_sym_q;
   logic              last_grant;
   logic              we_q;
   logic [SYM_W-1:0]  wdata_q;
   logic [SYM_W-1:0]  cur_sym;
   logic [SYM_W-1:0]  rd_q;
   logic [ADDR_W-1:0] home;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] seek_tgt;

   logic              core_v;
   logic              host_v;
   logic              grant_core;
   logic              issue;
   logic              iss_dir;
   logic [SYM_W-1:0]  iss_sym;

   // Shorter way round the ring; an exact half-turn goes right.
   function automatic logic seek_right(input logic [ADDR_W-1:0] from,
                                       input logic [ADDR_W-1:0] to);
      logic [ADDR_W-1:0] diff;
      diff = to - from;
      return diff <= HALF;
   endfunction

   // A core_step arriving in the same IDLE cycle as host_req competes directly.
   assign core_v     = core_pending | core_step;
   assign host_v     = host_req;
   assign grant_core = core_v && (!host_v || last_grant == LG_HOST);
   assign seek_tgt   = (state == RETURN) ? home : addr_q;

   always_comb begin
      issue   = 1'b0;
      iss_dir = 1'b0;
      iss_sym = cur_sym;
      case (state)
         CORE_WAIT: if (!outstanding) begin
            issue   = 1'b1;
            iss_dir = core_dir_q;
            iss_sym = core_sym_q;
         end
         SEEK, RETURN: if (!outstanding && head_pos != seek_tgt) begin
            issue   = 1'b1;
            iss_dir = seek_right(head_pos, seek_tgt);
         end
         WR: if (!outstanding) begin
            issue   = 1'b1;
            iss_dir = 1'b1;
            iss_sym = wdata_q;
         end
         FIX: if (!outstanding) begin
            issue   = 1'b1;
            iss_dir = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         outstanding    <= 1'b0;
         core_pending   <= 1'b0;
         core_dir_q     <= 1'b0;
         core_sym_q     <= '0;
         last_grant     <= LG_HOST;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         cur_sym        <= '0;
         rd_q           <= '0;
         home           <= '0;
         addr_q         <= '0;
         head_pos       <= '0;
         core_sym       <= '0;
         core_sym_valid <= 1'b0;
         host_ack       <= 1'b0;
         host_rdata     <= '0;
         host_busy      <= 1'b0;
         tape_step      <= 1'b0;
         tape_dir       <= 1'b0;
         tape_new_sym   <= '0;
      end else begin
         tape_step      <= issue;
         core_sym_valid <= 1'b0;
         host_ack       <= 1'b0;
         if (issue) begin
            tape_dir     <= iss_dir;
            tape_new_sym <= iss_sym;
            head_pos     <= iss_dir ? head_pos + ONE : head_pos - ONE;
            outstanding  <= 1'b1;
         end
         if (tape_sym_valid) cur_sym <= tape_sym;

         // Only one core step may wait; extra pulses while one is pending are dropped.
         if (core_step && !core_pending) begin
            core_sym_q <= core_new_sym;
            core_dir_q <= core_dir;
         end
         if (state == IDLE && grant_core) core_pending <= 1'b0;
         else if (core_step)              core_pending <= 1'b1;

         case (state)
            IDLE: begin
               if (tape_sym_valid) begin
                  core_sym       <= tape_sym;
                  core_sym_valid <= 1'b1;
               end
               // last_grant only records tie-break winners, so contention alternates.
               if (grant_core) begin
                  state <= CORE_WAIT;
                  if (host_v) last_grant <= LG_CORE;
               end else if (host_v) begin
                  state     <= SEEK;
                  home      <= head_pos;
                  addr_q    <= host_addr;
                  we_q      <= host_we;
                  wdata_q   <= host_wdata;
                  host_busy <= 1'b1;
                  if (core_v) last_grant <= LG_HOST;
               end
            end
            CORE_WAIT: if (outstanding && tape_sym_valid) begin
               core_sym       <= tape_sym;
               core_sym_valid <= 1'b1;
               outstanding    <= 1'b0;
               state          <= IDLE;
            end
            SEEK: begin
               if (outstanding) begin
                  if (tape_sym_valid) outstanding <= 1'b0;
               end else if (head_pos == addr_q) begin
                  if (we_q) state <= WR;
                  else begin
                     rd_q  <= cur_sym;
                     state <= RETURN;
                  end
               end
            end
            WR: if (outstanding && tape_sym_valid) begin
               outstanding <= 1'b0;
               state       <= FIX;
            end
            FIX: if (outstanding && tape_sym_valid) begin
               outstanding <= 1'b0;
               state       <= RETURN;
            end
            RETURN: begin
               if (outstanding) begin
                  if (tape_sym_valid) outstanding <= 1'b0;
               end else if (head_pos == home) begin
                  host_ack <= 1'b1;
                  if (!we_q) host_rdata <= rd_q;
                  state <= ACK;
               end
            end
            ACK: begin
               host_busy <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/tape_arbiter.md
Name: tape_arbiter

Overview:
Shares the single tape_interface head between the UTM core and a host load/dump port. It owns all tape_step traffic and tracks the absolute head position. Host accesses are served by seeking the head to the target cell, reading or writing it, and seeking back. The core sees an unchanged tape and head afterwards; only latency differs.

Parameters:
ADDR_W, 9, head position width; tape length 2**ADDR_W (512 cells), wraps modulo length
SYM_W, 3, symbol width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
core_step  in  1  one-cycle pulse: core requests write core_new_sym + move core_dir
core_new_sym  in  SYM_W  symbol to write, sampled with core_step
core_dir  in  1  1=right, 0=left, sampled with core_step
core_sym  out  SYM_W  symbol under head, valid with core_sym_valid
core_sym_valid  out  1  one-cycle pulse: core step complete
host_req  in  1  level; held with addr/we/wdata stable until host_ack
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  target cell
host_wdata  in  SYM_W  write data
host_ack  out  1  one-cycle pulse: access done
host_rdata  out  SYM_W  read data, valid with host_ack, held until next ack
host_busy  out  1  high from host grant to host_ack inclusive
tape_step  out  1  one-cycle pulse to tape_interface
tape_dir  out  1  move direction, valid with tape_step
tape_new_sym  out  SYM_W  symbol to write, valid with tape_step
tape_sym  in  SYM_W  symbol under head
tape_sym_valid  in  1  pulse: tape_sym is new head cell
head_pos  out  ADDR_W  absolute head position

Behaviour:
- Tape contract: tape_step writes tape_new_sym at head, moves head ±1 mod 2**ADDR_W, returns tape_sym_valid ≥1 cycle later. At most one step outstanding.
- cur_sym register loads tape_sym on every tape_sym_valid. head_pos updates on tape_step issue (+1 right, −1 left, wraps 511↔0).
- Reset (asserted low, async): state IDLE, head_pos 0, cur_sym 0, all outputs 0, pending flags cleared, last_grant=HOST. Mid-operation reset abandons the access with no ack; tape_interface is reset concurrently.
- core_step latches core_pending and the core symbol/direction. Pulses during an outstanding step or host access are held and issued later. A second core_step while pending is a protocol error and is ignored.
- tape_sym_valid in IDLE with nothing outstanding (power-up symbol) is forwarded to the core as core_sym_valid.
- Arbitration in IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant. Core wins the first tie.
  - Grant takes 1 cycle. tape_step is issued the cycle after grant.
- States:
  - IDLE.
  - CORE_WAIT: step issued; on tape_sym_valid pulse core_sym_valid with core_sym=tape_sym; go to IDLE.
  - SEEK: save home=head_pos; latch addr/we/wdata. While head_pos≠addr, step toward addr writing cur_sym back unchanged and wait for valid each step.
    - Direction is the shorter way mod 512; distance exactly 256 goes right.
    - When head_pos==addr: read goes to RETURN with rdata=cur_sym; write goes to WR.
  - WR: step writing host_wdata, dir right; wait.
  - FIX: step writing cur_sym, dir left; wait. Head is back at addr, cell addr+1 is unchanged.
  - RETURN: seek to home, same rules as SEEK.
  - ACK: pulse host_ack for one cycle, then go to IDLE.
- Step counts: read = 2d tape_steps; write = 2d+2 tape_steps, where d is the shortest distance from home to addr.
- Host write with d=0: WR and FIX only. Host read with d=0: ack with no tape_step.
- core_sym_valid never pulses for host-generated steps.

Test Plan:
- Reset release, tape model returns cell0=5 → one core_sym_valid pulse, core_sym=5, head_pos=0.
- core_step sym=3 dir=1 at head 0 → exactly 1 tape_step (new_sym 3, dir 1), head_pos=1, then one core_sym_valid.
- Head at 10, host read addr 13 (cell 13 = 6) → 6 tape_steps (3 right, 3 left), host_rdata=6, head_pos back to 10, tape contents unchanged.
- Head at 2, host write addr 509 data 7 → 5 left steps, write, fix, 5 right steps: 12 tape_steps total; cell 509=7, cell 510 unchanged, head_pos=2.
- core_step and host_req in the same IDLE cycle after reset → core served first, host next. Repeat the tie → host first.
- Assert reset mid-SEEK → all outputs 0 immediately, head_pos=0, no host_ack.
